// File: rtl/matvec_pkg.sv
// Shared constants and helpers for the 3x3 matrix-vector datapath.
// sat_to_width clips a signed accumulator value into a narrower signed range.
package matvec_pkg;

  localparam int MAT_DIM = 3;
  localparam int DATA_W  = 14;
  localparam int ACC_W   = 28;

  typedef struct packed {
    logic [ACC_W-1:0] value;
    logic             clipped;
  } sat_result_t;

  // The result stays ACC_W wide; the caller keeps only the low out_w bits,
  // which hold the correctly clipped two's-complement value.
  function automatic sat_result_t sat_to_width(input logic signed [ACC_W-1:0] value,
                                               input int out_w);
    sat_result_t res;
    longint      v;
    longint      max_v;
    longint      min_v;
    v           = longint'(value);
    max_v       = (longint'(1) << (out_w - 1)) - 1;
    min_v       = -max_v - 1;
    res.value   = value;
    res.clipped = 1'b0;
    if (v > max_v) begin
      res.value   = ACC_W'(max_v);
      res.clipped = 1'b1;
    end else if (v < min_v) begin
      res.value   = ACC_W'(min_v);
      res.clipped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO for packed result vectors.
// The head entry is presented combinationally on pop_data.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("result_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/matvec_result_packer.sv
// Collects N serial dot-product results, saturates each to OUT_W bits and
// queues the packed vector (plus per-element clip flags) for the consumer.
module matvec_result_packer
  import matvec_pkg::*;
#(
  parameter int IN_W       = ACC_W,
  parameter int OUT_W      = 16,
  parameter int N          = MAT_DIM,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*OUT_W-1:0] out_data,
  output logic [N-1:0]       out_sat
);

  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int VEC_W   = N * OUT_W;
  localparam int ENTRY_W = VEC_W + N;

  generate
    if (OUT_W > IN_W || OUT_W < 2) begin : g_bad_out_w
      $error("matvec_result_packer: OUT_W must lie in 2..IN_W");
    end
    if (N < 1) begin : g_bad_n
      $error("matvec_result_packer: N must be at least 1");
    end
    if (IN_W > ACC_W) begin : g_bad_in_w
      $error("matvec_result_packer: IN_W must not exceed the accumulator width");
    end
  endgenerate

  logic [CNT_W-1:0]        elem_cnt;
  logic [VEC_W-1:0]        asm_data;
  logic [N-1:0]            asm_sat;
  logic signed [ACC_W-1:0] in_ext;
  sat_result_t             sat_res;
  logic [OUT_W-1:0]        sat_elem;
  logic                    sat_flag;
  logic                    last_lane;
  logic                    accept;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [VEC_W-1:0]        push_vec;
  logic [N-1:0]            push_sat;
  logic [ENTRY_W-1:0]      head;
  logic                    unused_sat_bits;

  assign in_ext          = ACC_W'($signed(in_data));
  assign sat_res         = sat_to_width(in_ext, OUT_W);
  assign sat_elem        = sat_res.value[OUT_W-1:0];
  assign sat_flag        = sat_res.clipped;
  assign unused_sat_bits = &{1'b0, sat_res.value};

  // Only the closing lane needs a FIFO slot, so earlier lanes never stall.
  assign last_lane = (elem_cnt == CNT_W'(N - 1));
  assign in_ready  = !last_lane || !fifo_full;
  assign accept    = in_valid && in_ready;

  // The closing element bypasses the assembly register straight into the FIFO.
  always_comb begin
    push_vec                          = asm_data;
    push_sat                          = asm_sat;
    push_vec[(N-1)*OUT_W +: OUT_W]    = sat_elem;
    push_sat[N-1]                     = sat_flag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      elem_cnt <= '0;
      asm_data <= '0;
      asm_sat  <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (elem_cnt == CNT_W'(i)) begin
          asm_data[i*OUT_W +: OUT_W] <= sat_elem;
          asm_sat[i]                 <= sat_flag;
        end
      end
      if (last_lane) begin
        elem_cnt <= '0;
      end else begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && last_lane),
    .push_data ({push_sat, push_vec}),
    .pop       (out_valid && out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid           = !fifo_empty;
  assign {out_sat, out_data} = head;

endmodule

// File: doc/matvec_result_packer.md
Name: matvec_result_packer

Overview:
- Downstream stage of the 3x3 matrix-vector unit.
- Consumes that unit's serial stream of signed 28-bit dot-product results, one per valid/ready handshake.
- Groups every N consecutive results into one output vector, saturates each element to OUT_W bits and packs them into a single word.
- Buffers packed vectors in a small FIFO and presents them on a valid/ready output, so the matrix-vector unit never stalls while the consumer is ready.

Parameters:
- IN_W, 28, width of signed input results; must equal the matrix-vector accumulator width.
- OUT_W, 16, width of each signed saturated output element; legal range 2..IN_W.
- N, 3, elements per vector (matrix dimension).
- FIFO_DEPTH, 2, number of packed vectors buffered; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  this block accepts in_data this cycle.
- in_data  in  IN_W  signed dot-product result.
- out_valid  out  1  packed vector available.
- out_ready  in  1  downstream accepts the packed vector.
- out_data  out  N*OUT_W  packed vector; element 0 (first received) in bits [OUT_W-1:0].
- out_sat  out  N  per-element saturation flags; bit i set when element i was clipped.

Behaviour:
- Reset (reset==0 at a clk edge):
  - element counter = 0; assembly register = 0; FIFO emptied.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-vector discards the partial vector and all buffered vectors.
- Input accept: an element is accepted when in_valid && in_ready.
  - Accepted element i = elem_cnt goes to lane i.
  - elem_cnt increments 0..N-1 and wraps to 0 after lane N-1.
- Saturation, applied combinationally on in_data before storage:
  - in_data > 2^(OUT_W-1)-1 → stored as 2^(OUT_W-1)-1, flag set.
  - in_data < -2^(OUT_W-1) → stored as -2^(OUT_W-1), flag set.
  - Otherwise in_data[OUT_W-1:0] is stored, flag clear.
  - When OUT_W==IN_W, saturation is a passthrough and flags are always 0.
- Push: on acceptance of lane N-1, the completed vector is written into the FIFO in the same cycle, built from lanes 0..N-2 of the assembly register plus the current saturated lane.
  - The vector's N flags are written alongside it.
  - The assembly register is not cleared.
- in_ready = (elem_cnt != N-1) || !fifo_full.
  - Lanes 0..N-2 are always accepted.
  - The final lane stalls only while the FIFO is full.
  - in_ready does not depend combinationally on out_ready.
- Output:
  - out_valid = !fifo_empty.
  - out_data and out_sat are driven from the FIFO head entry and held stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
- Latency: a vector is visible on out_valid the cycle after its last element is accepted, provided the FIFO was empty.
- Simultaneous push and pop:
  - Allowed whenever in_ready is high; occupancy unchanged and order preserved.
  - When full, a push cannot occur, so a pop just frees a slot; in_ready for the last lane rises the following cycle.
- Throughput: one element per cycle sustained when out_ready is held high.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty use a count or an extra pointer bit, never ambiguous.
- in_valid while in_ready==0: the element is held upstream, no state change.
- Elaboration error if OUT_W > IN_W or N < 1.

Decomposition:
- Shared package matvec_pkg holds:
  - constants MAT_DIM=3, DATA_W=14, ACC_W=28;
  - function sat_to_width (signed clip, returns value and flag).
- Parameter defaults reference these constants.
- One sub-module: result_fifo, a synchronous FIFO parameterised by width and depth, with push/pop/full/empty and the same clk/reset.
- The packer top holds the element counter, assembly register and saturation logic.

Test Plan (OUT_W=16, N=3, FIFO_DEPTH=2):
- Basic vector: send 5, -7, 100 with out_ready=1 → one cycle after the third accept, out_valid=1, out_data=0x0064_FFF9_0005, out_sat=3'b000.
- Saturation: send 40000, -40000, 32767 → out_data=0x7FFF_8000_7FFF, out_sat=3'b011.
- Backpressure:
  - out_ready=0, offer 9 elements continuously → 8 accepted.
  - in_ready=0 while the 9th is offered; out_valid stays 1 with the first vector stable.
  - Raise out_ready → vectors pop in order, and the 9th element is accepted the cycle after the first pop.
- Reset mid-vector:
  - Accept 11, 22; pull reset low for one cycle (out_valid/out_sat/out_data → 0).
  - Then send 1, 2, 3 → the first output is 0x0003_0002_0001.
- Streaming: out_ready=1, 30 back-to-back elements 0..29 → 10 vectors in order, in_ready never drops, each vector out_valid one cycle after its last element.
- Simultaneous push/pop:
  - FIFO holds 1 vector and out_ready=1 on the cycle the next vector's last element is accepted.
  - Required: occupancy stays 1, out_valid stays 1, and the next out_data equals the new vector.
